// File: rtl/i2c_write_engine.sv
// I2C master write engine: START, three bytes (each followed by an ack slot), STOP.
// Handshake with the config sequencer is a level GO/END pair; oACK flags any NACK.
module i2c_write_engine #(
  parameter int CLK_Freq = 50000000,
  parameter int I2C_Freq = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int DIV = CLK_Freq / (4 * I2C_Freq);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

  state_t      state, stateNext;
  logic [1:0]  phase, phaseNext;
  logic [4:0]  bitCnt, bitNext;
  logic [23:0] shiftReg, shiftNext;
  logic [DW-1:0] divCnt;
  logic        tick;
  logic        accept, ackSlot, ackSlotNext, ackSample;
  logic        sclkReg, sdaLow, sclkNext, sdaLowNext;

  // Bus levels for a given state/phase; returns {SCLK, pull SDA low}.
  function automatic logic [1:0] busDrive(input state_t st, input logic [1:0] ph,
                                          input logic ackSl, input logic bitVal);
    logic sclk, low;
    sclk = 1'b1;
    low  = 1'b0;
    case (st)
      START: begin sclk = (ph <= 2'd1); low = (ph != 2'd0); end
      BITS:  begin sclk = (ph == 2'd1) || (ph == 2'd2); low = !ackSl && !bitVal; end
      STOP:  begin sclk = (ph != 2'd0); low = (ph <= 2'd1); end
      default: ;
    endcase
    return {sclk, low};
  endfunction

  assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;
  assign I2C_SCLK = sclkReg;

  always_comb begin
    stateNext = state;
    phaseNext = phase;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    accept    = 1'b0;
    ackSample = 1'b0;
    ackSlot   = (bitCnt == 5'd8) || (bitCnt == 5'd17) || (bitCnt == 5'd26);
    case (state)
      IDLE: begin
        if (iGO && !oEND) begin
          accept    = 1'b1;
          stateNext = START;
          phaseNext = 2'd0;
          bitNext   = 5'd0;
          shiftNext = iDATA;
        end
      end
      START: begin
        if (tick) begin
          phaseNext = phase + 2'd1;
          if (phase == 2'd3) stateNext = BITS;
        end
      end
      BITS: begin
        if (tick) begin
          phaseNext = phase + 2'd1;
          if (phase == 2'd2 && ackSlot) ackSample = 1'b1;
          if (phase == 2'd3) begin
            if (!ackSlot) shiftNext = {shiftReg[22:0], 1'b0};
            if (bitCnt == 5'd26) stateNext = STOP;
            else                 bitNext   = bitCnt + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          phaseNext = phase + 2'd1;
          if (phase == 2'd3) stateNext = DONE;
        end
      end
      DONE: begin
        if (!iGO) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    ackSlotNext = (bitNext == 5'd8) || (bitNext == 5'd17) || (bitNext == 5'd26);
    {sclkNext, sdaLowNext} = busDrive(stateNext, phaseNext, ackSlotNext, shiftNext[23]);
  end

  // Outputs are registered from the next state so the bus lines never glitch.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      phase   <= 2'd0;
      bitCnt  <= 5'd0;
      divCnt  <= '0;
      tick    <= 1'b0;
      sclkReg <= 1'b1;
      sdaLow  <= 1'b0;
      oEND    <= 1'b0;
      oACK    <= 1'b0;
      oBUSY   <= 1'b0;
    end else begin
      state   <= stateNext;
      phase   <= phaseNext;
      bitCnt  <= bitNext;
      sclkReg <= sclkNext;
      sdaLow  <= sdaLowNext;
      oEND    <= (stateNext == DONE);
      oBUSY   <= (stateNext == START) || (stateNext == BITS) || (stateNext == STOP);
      if (accept) begin
        divCnt <= '0;
        tick   <= 1'b0;
      end else begin
        divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
        tick   <= (divCnt == DIV_LAST);
      end
      if (accept)                     oACK <= 1'b0;
      else if (ackSample && I2C_SDAT) oACK <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    shiftReg <= shiftNext;
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine with DIV=4 and a behavioural I2C slave that
// decodes bytes, drives acks (optionally NACKs per byte) and counts START/STOP.
module tb_i2c_write_engine;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [23:0] iDATA = 24'h0;
  logic        iGO = 1'b0;
  logic        oEND, oACK, oBUSY, sclk;
  wire         sda;

  int checks = 0;
  int errors = 0;

  i2c_write_engine #(.CLK_Freq(400), .I2C_Freq(25)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iGO(iGO),
    .oEND(oEND), .oACK(oACK), .oBUSY(oBUSY),
    .I2C_SCLK(sclk), .I2C_SDAT(sda)
  );

  always #5 iCLK = ~iCLK;

  // Slave model
  pullup (sda);
  logic       slaveLow = 1'b0;
  logic [2:0] nackMask = 3'b000;
  logic [3:0] bitIdx = 4'd0;
  logic [1:0] byteIdx = 2'd0;
  logic       acking = 1'b0;
  logic [7:0] shiftIn = 8'h00;
  logic [7:0] rxByte [3] = '{8'h00, 8'h00, 8'h00};
  logic       prevSda = 1'b1;
  logic       prevScl = 1'b1;
  int         startCnt = 0;
  int         stopCnt = 0;

  assign sda = slaveLow ? 1'b0 : 1'bz;

  always @(sda or sclk) begin
    if (sclk && prevScl && prevSda && !sda) begin
      startCnt++;
      bitIdx   = 4'd0;
      byteIdx  = 2'd0;
      acking   = 1'b0;
      slaveLow = 1'b0;
    end else if (sclk && prevScl && !prevSda && sda) begin
      stopCnt++;
    end else if (sclk && !prevScl) begin
      if (bitIdx < 4'd8) begin
        shiftIn = {shiftIn[6:0], sda};
        bitIdx  = bitIdx + 4'd1;
      end
    end else if (!sclk && prevScl) begin
      if (bitIdx == 4'd8 && !acking && byteIdx < 2'd3) begin
        rxByte[byteIdx] = shiftIn;
        slaveLow = !nackMask[byteIdx];
        acking   = 1'b1;
      end else if (acking) begin
        slaveLow = 1'b0;
        acking   = 1'b0;
        bitIdx   = 4'd0;
        byteIdx  = byteIdx + 2'd1;
      end
    end
    prevSda = sda;
    prevScl = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise GO and wait for oEND; lat counts edges from the acceptance edge (-1 on timeout).
  task automatic doXfer(input logic [23:0] word, input logic [2:0] nack, input logic corrupt,
                        output int lat, output logic ackAtStart, output logic busyAtStart);
    @(negedge iCLK);
    nackMask = nack;
    iDATA    = word;
    iGO      = 1'b1;
    @(posedge iCLK);
    #1;
    ackAtStart  = oACK;
    busyAtStart = oBUSY;
    if (corrupt) iDATA = 24'hFFFFFF;
    lat = -1;
    for (int n = 1; n <= 600; n++) begin
      @(posedge iCLK);
      #1;
      if (oEND) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic dropGo();
    @(negedge iCLK);
    iGO = 1'b0;
    @(posedge iCLK);
    #1;
  endtask

  logic [23:0] cfg [11] = '{24'h341E00, 24'h34001A, 24'h34021A, 24'h34047B, 24'h34067B,
                            24'h3408F8, 24'h340A06, 24'h340C00, 24'h340E01, 24'h341002,
                            24'h341201};

  initial begin
    int   lat, s0, p0;
    logic ackS, busyS, endHeld, busyMid;

    // Reset state
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_sclk", sclk, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_end", oEND, 1'b0);
    check("rst_ack", oACK, 1'b0);
    check("rst_busy", oBUSY, 1'b0);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(posedge iCLK);

    // 1: all bytes acked
    s0 = startCnt; p0 = stopCnt;
    doXfer(24'h341E00, 3'b000, 1'b0, lat, ackS, busyS);
    check("t1_busy_start", busyS, 1'b1);
    check("t1_latency", lat, 465);
    check("t1_bytes", {rxByte[0], rxByte[1], rxByte[2]}, 24'h341E00);
    check("t1_nbytes", byteIdx, 2'd3);
    check("t1_start", startCnt - s0, 1);
    check("t1_stop", stopCnt - p0, 1);
    check("t1_ack", oACK, 1'b0);
    check("t1_busy_end", oBUSY, 1'b0);
    check("t1_sclk_idle", sclk, 1'b1);
    dropGo();
    check("t1_end_drop", oEND, 1'b0);

    // 2: NACK on the second byte, STOP still generated
    s0 = startCnt; p0 = stopCnt;
    doXfer(24'h341E00, 3'b010, 1'b0, lat, ackS, busyS);
    check("t2_latency", lat, 465);
    check("t2_bytes", {rxByte[0], rxByte[1], rxByte[2]}, 24'h341E00);
    check("t2_stop", stopCnt - p0, 1);
    check("t2_end", oEND, 1'b1);
    check("t2_ack", oACK, 1'b1);

    // 3: hold GO after oEND, then drop and re-raise
    s0 = startCnt;
    endHeld = 1'b1;
    busyMid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge iCLK);
      #1;
      if (!oEND) endHeld = 1'b0;
      if (oBUSY) busyMid = 1'b1;
    end
    check("t3_end_held", endHeld, 1'b1);
    check("t3_no_busy", busyMid, 1'b0);
    check("t3_no_start", startCnt - s0, 0);
    dropGo();
    check("t3_end_drop", oEND, 1'b0);
    check("t3_ack_kept", oACK, 1'b1);
    doXfer(24'h3402A5, 3'b000, 1'b0, lat, ackS, busyS);
    check("t3_ack_clear", ackS, 1'b0);
    check("t3_busy_start", busyS, 1'b1);
    check("t3_latency", lat, 465);
    check("t3_bytes", {rxByte[0], rxByte[1], rxByte[2]}, 24'h3402A5);
    check("t3_ack_end", oACK, 1'b0);
    dropGo();

    // 4: reset in the middle of a data bit (slot 1, SCLK high, SDA low)
    @(negedge iCLK);
    iDATA = 24'h341E00;
    iGO   = 1'b1;
    @(posedge iCLK);
    repeat (38) @(posedge iCLK);
    @(negedge iCLK);
    check("t4_pre_sclk", sclk, 1'b1);
    check("t4_pre_sda", sda, 1'b0);
    check("t4_pre_busy", oBUSY, 1'b1);
    iRST = 1'b1;
    #1;
    check("t4_rst_sclk", sclk, 1'b1);
    check("t4_rst_sda", sda, 1'b1);
    check("t4_rst_busy", oBUSY, 1'b0);
    check("t4_rst_end", oEND, 1'b0);
    @(negedge iCLK);
    iGO = 1'b0;
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (10) @(posedge iCLK);
    #1;
    check("t4_idle_busy", oBUSY, 1'b0);
    check("t4_idle_sclk", sclk, 1'b1);

    // 5: iDATA changed right after acceptance
    doXfer(24'h34A53C, 3'b000, 1'b1, lat, ackS, busyS);
    check("t5_latency", lat, 465);
    check("t5_bytes", {rxByte[0], rxByte[1], rxByte[2]}, 24'h34A53C);
    dropGo();
    check("t5_end_drop", oEND, 1'b0);

    // 6: codec configuration sweep
    for (int i = 0; i < 11; i++) begin
      doXfer(cfg[i], 3'b000, 1'b0, lat, ackS, busyS);
      check($sformatf("t6_latency_%0d", i), lat, 465);
      check($sformatf("t6_bytes_%0d", i), {rxByte[0], rxByte[1], rxByte[2]}, cfg[i]);
      check($sformatf("t6_ack_%0d", i), oACK, 1'b0);
      dropGo();
      check($sformatf("t6_end_drop_%0d", i), oEND, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
